// File: rtl/counter_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared constants for the first_counter block and its helpers.
//   COUNTER_WIDTH : default counter width (4 bits)
//   COUNT_MAX     : terminal count for the default width (2^WIDTH-1)
//   count_max()   : terminal count for an arbitrary width in 1..32
// -----------------------------------------------------------------------------
package counter_pkg;

  localparam int unsigned COUNTER_WIDTH = 4;

  // Computed by shifting an all-ones word rather than evaluating 2**w-1,
  // so a width of 32 cannot overflow 32-bit integer arithmetic.
  function automatic logic [31:0] count_max(input int unsigned w);
    return 32'hFFFF_FFFF >> (32 - w);
  endfunction

  localparam logic [31:0] COUNT_MAX = count_max(COUNTER_WIDTH);

endpackage : counter_pkg

// File: rtl/counter_wrap_detect.sv
// -----------------------------------------------------------------------------
// counter_wrap_detect
// Combinational wrap detector. It asserts a pulse when an enabled increment
// would take an up-counter from its terminal value back to zero.
// Ports:
//   i_count  [WIDTH-1:0] : current counter value
//   i_enable             : increment enable for this cycle
//   o_wrap               : 1 when i_enable=1 and i_count == 2^WIDTH-1
// -----------------------------------------------------------------------------
module counter_wrap_detect
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_WIDTH
) (
  input  logic [WIDTH-1:0] i_count,
  input  logic             i_enable,
  output logic             o_wrap
);

  logic w_at_max;

  // The terminal value is all ones, so a reduction-AND is enough.
  assign w_at_max = &i_count;
  assign o_wrap   = i_enable & w_at_max;

endmodule : counter_wrap_detect

// File: rtl/first_counter.sv
// -----------------------------------------------------------------------------
// first_counter
// Free-running up-counter with a synchronous enable and a sticky overflow
// flag. The counter wraps modulo 2^WIDTH. The flag sets on the first wrap and
// stays set until the next reset. Both outputs come directly from registers,
// so no combinational path runs from an input to an output.
// Ports:
//   clk                      : system clock, rising edge active
//   reset                    : synchronous, active-high reset (dominates enable)
//   enable                   : count enable, sampled on the rising edge
//   counter_out [WIDTH-1:0]  : current count value
//   overflow_out             : sticky overflow flag
// Parameter:
//   WIDTH : counter width, legal range 1..32
// -----------------------------------------------------------------------------
module first_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH = COUNTER_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out,
  output logic             overflow_out
);

  logic [WIDTH-1:0] r_count;
  logic             r_overflow;
  logic             w_wrap;

  counter_wrap_detect #(
    .WIDTH (WIDTH)
  ) u_wrap_detect (
    .i_count  (r_count),
    .i_enable (enable),
    .o_wrap   (w_wrap)
  );

  // Register stage: the count and the sticky flag update together. Reset
  // takes priority, so a wrap on the same edge as reset leaves the flag clear.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (enable) begin
        r_count <= r_count + WIDTH'(1);
      end
      if (w_wrap) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign counter_out  = r_count;
  assign overflow_out = r_overflow;

endmodule : first_counter

// File: tb/tb_first_counter.sv
module tb_first_counter;

  localparam int unsigned WIDTH  = 4;
  localparam int unsigned MODULO = 1 << WIDTH;

  logic             clk;
  logic             reset;
  logic             enable;
  logic [WIDTH-1:0] counter_out;
  logic             overflow_out;

  int n_vec;
  int n_err;

  // Reference model: the number of enabled edges since the last reset.
  // The expected count is that number modulo 2^WIDTH. The flag is expected
  // once the number has reached 2^WIDTH.
  longint unsigned m_events;
  logic            m_valid;

  first_counter #(
    .WIDTH (WIDTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .counter_out  (counter_out),
    .overflow_out (overflow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Drive the inputs at the negedge, let one rising edge pass, update the
  // model, and sample 1 ns after the edge.
  task automatic tick(input logic r, input logic e);
    @(negedge clk);
    reset  = r;
    enable = e;
    @(posedge clk);
    if (r) begin
      m_events = 0;
      m_valid  = 1'b1;
    end else if (e) begin
      m_events = m_events + 1;
    end
    #1;
    if (m_valid) begin
      chk("count", 32'(counter_out), 32'(m_events % MODULO));
      chk("ovf",   32'(overflow_out), 32'(m_events >= MODULO));
    end
  endtask

  initial begin
    n_vec    = 0;
    n_err    = 0;
    m_events = 0;
    m_valid  = 1'b0;
    reset    = 1'b0;
    enable   = 1'b0;

    // Reset, followed by 5 idle edges.
    tick(1'b1, 1'b1);
    chk("rst_cnt", 32'(counter_out), 32'd0);
    chk("rst_ovf", 32'(overflow_out), 32'd0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b0);

    // Count 1..15 and wrap to 0. The flag rises on the wrap edge.
    for (int i = 0; i < 15; i++) tick(1'b0, 1'b1);
    chk("pre_wrap_cnt", 32'(counter_out), 32'd15);
    chk("pre_wrap_ovf", 32'(overflow_out), 32'd0);
    tick(1'b0, 1'b1);
    chk("wrap_cnt", 32'(counter_out), 32'd0);
    chk("wrap_ovf", 32'(overflow_out), 32'd1);

    // Continue to 100 enabled edges in total. The flag must stay set.
    for (int i = 0; i < 84; i++) tick(1'b0, 1'b1);
    chk("sticky_cnt", 32'(counter_out), 32'd4);
    chk("sticky_ovf", 32'(overflow_out), 32'd1);

    // Count to 7, hold for 3 edges, then resume counting to 8.
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0);
      chk("hold_cnt", 32'(counter_out), 32'd7);
    end
    tick(1'b0, 1'b1);
    chk("resume_cnt", 32'(counter_out), 32'd8);

    // Reset mid-count at 9 with the flag set, while enable is 1.
    tick(1'b0, 1'b1);
    chk("mid_pre_cnt", 32'(counter_out), 32'd9);
    tick(1'b1, 1'b1);
    chk("mid_rst_cnt", 32'(counter_out), 32'd0);
    chk("mid_rst_ovf", 32'(overflow_out), 32'd0);
    tick(1'b0, 1'b1);
    chk("post_rst_cnt", 32'(counter_out), 32'd1);

    // Reset on the same edge as a wrap: reset wins.
    for (int i = 0; i < 14; i++) tick(1'b0, 1'b1);
    chk("sim_pre_cnt", 32'(counter_out), 32'd15);
    tick(1'b1, 1'b1);
    chk("sim_cnt", 32'(counter_out), 32'd0);
    chk("sim_ovf", 32'(overflow_out), 32'd0);

    // Randomized enable with occasional reset, checked against the model.
    for (int i = 0; i < 2000; i++) begin
      tick(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_first_counter
